// File: rtl/csr_priv_unit.sv
// rtl/csr_priv_unit.sv - machine/supervisor CSR file with privilege-mode tracking
module csr_priv_unit #(
    parameter logic [31:0] MTVEC_RST = 32'h0000_0000,
    parameter logic [31:0] HART_ID   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        csr_valid,
    input  logic [1:0]  csr_op,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wdata,
    input  logic [1:0]  priv_ret,
    input  logic        trap_valid,
    input  logic [31:0] trap_cause,
    input  logic [31:0] trap_pc,
    output logic [31:0] csr_rdata,
    output logic        csr_illegal,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic [1:0]  priv_mode
);

    localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
    localparam logic [11:0] ADDR_MTVEC    = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
    localparam logic [11:0] ADDR_MEPC     = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
    localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
    localparam logic [11:0] ADDR_SSTATUS  = 12'h100;
    localparam logic [11:0] ADDR_STVEC    = 12'h105;
    localparam logic [11:0] ADDR_SSCRATCH = 12'h140;
    localparam logic [11:0] ADDR_SEPC     = 12'h141;
    localparam logic [11:0] ADDR_SCAUSE   = 12'h142;
    localparam logic [11:0] ADDR_MHARTID  = 12'hF14;

    localparam logic [31:0] SSTATUS_MASK  = 32'h0000_0122;
    localparam logic [31:0] ALIGN_MASK    = 32'hFFFF_FFFC;
    localparam logic [1:0]  MODE_M        = 2'b11;
    localparam logic [1:0]  MODE_U        = 2'b00;

    // mstatus is held as individual fields; all other bits read as zero
    logic        sie, mie, spie, mpie, spp;
    logic [1:0]  mpp;
    logic [31:0] mtvec, stvec, mepc, sepc, mcause, scause;
    logic [31:0] mscratch, sscratch, mcycle;
    logic [31:0] mstatus;
    logic        mapped;

    assign mstatus = {19'b0, mpp, 2'b0, spp, mpie, 1'b0, spie, 1'b0, mie, 1'b0, sie, 1'b0};

    // Zero-latency read mux; unmapped addresses read zero
    always_comb begin
        csr_rdata = 32'h0;
        mapped    = 1'b1;
        case (csr_addr)
            ADDR_MSTATUS:  csr_rdata = mstatus;
            ADDR_MTVEC:    csr_rdata = mtvec;
            ADDR_MSCRATCH: csr_rdata = mscratch;
            ADDR_MEPC:     csr_rdata = mepc;
            ADDR_MCAUSE:   csr_rdata = mcause;
            ADDR_MCYCLE:   csr_rdata = mcycle;
            ADDR_SSTATUS:  csr_rdata = mstatus & SSTATUS_MASK;
            ADDR_STVEC:    csr_rdata = stvec;
            ADDR_SSCRATCH: csr_rdata = sscratch;
            ADDR_SEPC:     csr_rdata = sepc;
            ADDR_SCAUSE:   csr_rdata = scause;
            ADDR_MHARTID:  csr_rdata = HART_ID;
            default:       mapped    = 1'b0;
        endcase
    end

    // Access / return legality and the resulting action selection
    logic        op_active, write_effect, is_mret, is_sret;
    logic        mret_take, sret_take, do_write;
    logic [31:0] wval;

    assign op_active    = csr_valid && (csr_op == 2'b01 || csr_op == 2'b10);
    // csrrs with a zero mask is a pure read and must not trip the read-only check
    assign write_effect = op_active && (csr_op == 2'b01 || csr_wdata != 32'h0);
    assign is_mret      = csr_valid && (priv_ret == 2'b01);
    assign is_sret      = csr_valid && (priv_ret == 2'b10);

    assign csr_illegal  = (op_active && !mapped)
                       || (op_active && (csr_addr[9:8] > priv_mode))
                       || (write_effect && (csr_addr[11:10] == 2'b11))
                       || (is_mret && (priv_mode != MODE_M))
                       || (is_sret && (priv_mode == MODE_U));

    assign mret_take    = is_mret && !csr_illegal && !trap_valid;
    assign sret_take    = is_sret && !csr_illegal && !trap_valid;
    assign do_write     = write_effect && !csr_illegal && !trap_valid && !mret_take && !sret_take;
    assign wval         = (csr_op == 2'b01) ? csr_wdata : (csr_rdata | csr_wdata);

    assign redirect_valid = trap_valid || mret_take || sret_take;
    assign redirect_pc    = trap_valid ? mtvec : (mret_take ? mepc : sepc);

    // State update: trap beats returns, returns beat CSR writes; mcycle always counts
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            priv_mode <= MODE_M;
            sie       <= 1'b0;
            mie       <= 1'b0;
            spie      <= 1'b0;
            mpie      <= 1'b0;
            spp       <= 1'b0;
            mpp       <= 2'b00;
            mtvec     <= MTVEC_RST & ALIGN_MASK;
            stvec     <= MTVEC_RST & ALIGN_MASK;
            mepc      <= 32'h0;
            sepc      <= 32'h0;
            mcause    <= 32'h0;
            scause    <= 32'h0;
            mscratch  <= 32'h0;
            sscratch  <= 32'h0;
            mcycle    <= 32'h0;
        end else begin
            mcycle <= mcycle + 32'd1;
            if (trap_valid) begin
                mepc      <= trap_pc & ALIGN_MASK;
                mcause    <= trap_cause;
                mpie      <= mie;
                mie       <= 1'b0;
                mpp       <= priv_mode;
                priv_mode <= MODE_M;
            end else if (mret_take) begin
                priv_mode <= mpp;
                mie       <= mpie;
                mpie      <= 1'b1;
                mpp       <= 2'b00;
            end else if (sret_take) begin
                priv_mode <= {1'b0, spp};
                sie       <= spie;
                spie      <= 1'b1;
                spp       <= 1'b0;
            end else if (do_write) begin
                case (csr_addr)
                    ADDR_MSTATUS: begin
                        sie  <= wval[1];
                        mie  <= wval[3];
                        spie <= wval[5];
                        mpie <= wval[7];
                        spp  <= wval[8];
                        // MPP=10 is reserved; keep the previous mode
                        if (wval[12:11] != 2'b10) begin
                            mpp <= wval[12:11];
                        end
                    end
                    ADDR_SSTATUS: begin
                        sie  <= wval[1];
                        spie <= wval[5];
                        spp  <= wval[8];
                    end
                    ADDR_MTVEC:    mtvec    <= wval & ALIGN_MASK;
                    ADDR_STVEC:    stvec    <= wval & ALIGN_MASK;
                    ADDR_MEPC:     mepc     <= wval & ALIGN_MASK;
                    ADDR_SEPC:     sepc     <= wval & ALIGN_MASK;
                    ADDR_MCAUSE:   mcause   <= wval;
                    ADDR_SCAUSE:   scause   <= wval;
                    ADDR_MSCRATCH: mscratch <= wval;
                    ADDR_SSCRATCH: sscratch <= wval;
                    ADDR_MCYCLE:   mcycle   <= wval;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_csr_priv_unit.sv
// tb/tb_csr_priv_unit.sv - scoreboard bench for csr_priv_unit
module tb_csr_priv_unit;

    localparam logic [31:0] MTVEC_RST = 32'h0000_1003;
    localparam logic [31:0] HART_ID   = 32'h0000_0005;

    localparam int K_RDATA = 0;
    localparam int K_ILL   = 1;
    localparam int K_RV    = 2;
    localparam int K_RPC   = 3;
    localparam int K_PRIV  = 4;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        csr_valid = 1'b0;
    logic [1:0]  csr_op = 2'b00;
    logic [11:0] csr_addr = 12'h0;
    logic [31:0] csr_wdata = 32'h0;
    logic [1:0]  priv_ret = 2'b00;
    logic        trap_valid = 1'b0;
    logic [31:0] trap_cause = 32'h0;
    logic [31:0] trap_pc = 32'h0;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [1:0]  priv_mode;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int          kind;
        string       tag;
        logic [31:0] val;
    } exp_t;
    exp_t sb[$];

    logic [31:0] cyc_model;

    csr_priv_unit #(.MTVEC_RST(MTVEC_RST), .HART_ID(HART_ID)) dut (
        .clk(clk), .rstn(rstn),
        .csr_valid(csr_valid), .csr_op(csr_op), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
        .priv_ret(priv_ret), .trap_valid(trap_valid), .trap_cause(trap_cause), .trap_pc(trap_pc),
        .csr_rdata(csr_rdata), .csr_illegal(csr_illegal), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .priv_mode(priv_mode)
    );

    always #5 clk = ~clk;

    // Free-running cycle reference, valid while nothing writes mcycle
    always @(posedge clk or negedge rstn) begin
        if (!rstn) cyc_model <= 32'h0;
        else       cyc_model <= cyc_model + 32'd1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic expect_val(input int kind, input string tag, input logic [31:0] val);
        exp_t e;
        e.kind = kind;
        e.tag  = tag;
        e.val  = val;
        sb.push_back(e);
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [11:0] addr,
                         input logic [31:0] wd, input logic [1:0] ret, input logic tv,
                         input logic [31:0] cause, input logic [31:0] pc);
        @(negedge clk);
        csr_valid  = v;
        csr_op     = op;
        csr_addr   = addr;
        csr_wdata  = wd;
        priv_ret   = ret;
        trap_valid = tv;
        trap_cause = cause;
        trap_pc    = pc;
    endtask

    task automatic rd(input logic [11:0] addr);
        drive(1'b0, 2'b00, addr, 32'h0, 2'b00, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic csrrw(input logic [11:0] addr, input logic [31:0] wd);
        drive(1'b1, 2'b01, addr, wd, 2'b00, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic csrrs(input logic [11:0] addr, input logic [31:0] wd);
        drive(1'b1, 2'b10, addr, wd, 2'b00, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic settle(input int d);
        exp_t        e;
        logic [31:0] obs;
        #(d);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.kind)
                K_RDATA: obs = csr_rdata;
                K_ILL:   obs = {31'b0, csr_illegal};
                K_RV:    obs = {31'b0, redirect_valid};
                K_RPC:   obs = redirect_pc;
                default: obs = {30'b0, priv_mode};
            endcase
            check(e.tag, obs, e.val);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        csr_addr = 12'hB00;
        expect_val(K_RDATA, "mcycle0", 32'd0);
        expect_val(K_PRIV, "rst_priv", 32'd3);
        expect_val(K_ILL, "rst_ill", 32'd0);
        expect_val(K_RV, "rst_rv", 32'd0);
        settle(4);
        rd(12'hB00); expect_val(K_RDATA, "mcycle1", 32'd1); settle(4);
        rd(12'hB00); expect_val(K_RDATA, "mcycle2", 32'd2); settle(4);
        rd(12'h300); expect_val(K_RDATA, "rst_mstatus", 32'h0); settle(4);
        rd(12'h305); expect_val(K_RDATA, "rst_mtvec", 32'h1000); settle(4);
        rd(12'h105); expect_val(K_RDATA, "rst_stvec", 32'h1000); settle(4);

        // mepc alignment, csrrs set semantics, csrrs x0 on mcycle
        csrrw(12'h341, 32'h8000_0103); expect_val(K_RDATA, "mepc_old", 32'h0); expect_val(K_ILL, "mepc_ill", 32'h0); settle(4);
        rd(12'h341); expect_val(K_RDATA, "mepc_align", 32'h8000_0100); settle(4);
        csrrw(12'h340, 32'h0F); settle(4);
        csrrs(12'h340, 32'hF0); expect_val(K_RDATA, "mscratch_old", 32'h0F); settle(4);
        rd(12'h340); expect_val(K_RDATA, "mscratch_set", 32'hFF); settle(4);
        csrrs(12'hB00, 32'h0); expect_val(K_RDATA, "mcycle_rs0", cyc_model); expect_val(K_ILL, "mcycle_rs0_ill", 32'h0); settle(4);
        rd(12'hB00); expect_val(K_RDATA, "mcycle_after", cyc_model); settle(4);

        // trap from M with MIE=1
        csrrw(12'h300, 32'h8); settle(4);
        rd(12'h300); expect_val(K_RDATA, "mie_set", 32'h8); settle(4);
        drive(1'b0, 2'b00, 12'h305, 32'h0, 2'b00, 1'b1, 32'd2, 32'h104);
        expect_val(K_RV, "trap_rv", 32'd1); expect_val(K_RPC, "trap_rpc", 32'h1000); settle(4);
        rd(12'h341); expect_val(K_RDATA, "trap_mepc", 32'h104); settle(4);
        rd(12'h342); expect_val(K_RDATA, "trap_mcause", 32'd2); settle(4);
        rd(12'h300); expect_val(K_RDATA, "trap_mstatus", 32'h1880); expect_val(K_PRIV, "trap_priv", 32'd3); settle(4);

        // MPP=10 is kept as the old value
        csrrw(12'h300, 32'h1000); expect_val(K_RDATA, "warl_old", 32'h1880); settle(4);
        rd(12'h300); expect_val(K_RDATA, "warl_mpp", 32'h1800); settle(4);

        // mret to S, then sret to U
        csrrw(12'h300, 32'h0800); settle(4);
        csrrw(12'h341, 32'h200); settle(4);
        csrrw(12'h141, 32'h300); settle(4);
        drive(1'b1, 2'b00, 12'h0, 32'h0, 2'b01, 1'b0, 32'h0, 32'h0);
        expect_val(K_RV, "mret_rv", 32'd1); expect_val(K_RPC, "mret_rpc", 32'h200); expect_val(K_ILL, "mret_ill", 32'd0); settle(4);
        rd(12'h300); expect_val(K_RDATA, "mret_mstatus", 32'h80); expect_val(K_PRIV, "mret_priv", 32'd1); settle(4);
        drive(1'b1, 2'b00, 12'h0, 32'h0, 2'b10, 1'b0, 32'h0, 32'h0);
        expect_val(K_RV, "sret_rv", 32'd1); expect_val(K_RPC, "sret_rpc", 32'h300); settle(4);

        // U-mode illegal accesses
        csrrw(12'h300, 32'hFFFF); expect_val(K_PRIV, "u_priv", 32'd0); expect_val(K_ILL, "u_wr_ill", 32'd1);
        expect_val(K_RDATA, "u_rdata", 32'hA0); settle(4);
        rd(12'h300); expect_val(K_RDATA, "u_unchanged", 32'hA0); settle(4);
        drive(1'b1, 2'b00, 12'h0, 32'h0, 2'b01, 1'b0, 32'h0, 32'h0);
        expect_val(K_ILL, "u_mret_ill", 32'd1); expect_val(K_RV, "u_mret_rv", 32'd0); settle(4);
        csrrs(12'h100, 32'h0); expect_val(K_ILL, "u_sstatus_ill", 32'd1); settle(4);

        // trap out of U while an illegal sret is presented
        drive(1'b1, 2'b00, 12'h0, 32'h0, 2'b10, 1'b1, 32'd8, 32'h40C);
        expect_val(K_RV, "utrap_rv", 32'd1); expect_val(K_RPC, "utrap_rpc", 32'h1000); settle(4);
        rd(12'h300); expect_val(K_RDATA, "utrap_mstatus", 32'h20); expect_val(K_PRIV, "utrap_priv", 32'd3); settle(4);

        // trap beats a legal mret in the same cycle
        csrrw(12'h305, 32'h2001); expect_val(K_RDATA, "mtvec_old", 32'h1000); settle(4);
        drive(1'b1, 2'b00, 12'h0, 32'h0, 2'b01, 1'b1, 32'd3, 32'h50A);
        expect_val(K_RV, "prio_rv", 32'd1); expect_val(K_RPC, "prio_rpc", 32'h2000); settle(4);
        rd(12'h341); expect_val(K_RDATA, "prio_mepc", 32'h508); settle(4);
        rd(12'h300); expect_val(K_RDATA, "prio_mstatus", 32'h1820); expect_val(K_PRIV, "prio_priv", 32'd3); settle(4);
        rd(12'h342); expect_val(K_RDATA, "prio_mcause", 32'd3); settle(4);

        // mhartid, sstatus view, unmapped
        rd(12'hF14); expect_val(K_RDATA, "hartid", HART_ID); settle(4);
        csrrw(12'hF14, 32'h1); expect_val(K_ILL, "hartid_wr_ill", 32'd1); settle(4);
        csrrs(12'hF14, 32'h0); expect_val(K_ILL, "hartid_rd_ill", 32'd0); expect_val(K_RDATA, "hartid_rs", HART_ID); settle(4);
        csrrw(12'h100, 32'hFFFF_FFFF); expect_val(K_RDATA, "sstatus_old", 32'h20); settle(4);
        rd(12'h100); expect_val(K_RDATA, "sstatus_new", 32'h122); settle(4);
        rd(12'h300); expect_val(K_RDATA, "sstatus_view", 32'h1922); settle(4);
        rd(12'h123); expect_val(K_RDATA, "unmapped_rd", 32'h0); settle(4);
        csrrw(12'h7C0, 32'h1); expect_val(K_ILL, "unmapped_ill", 32'd1); settle(4);

        // mcycle write then wrap
        csrrw(12'hB00, 32'hFFFF_FFFF); expect_val(K_ILL, "mcycle_wr_ill", 32'd0); settle(4);
        rd(12'hB00); expect_val(K_RDATA, "mcycle_wr", 32'hFFFF_FFFF); settle(4);
        rd(12'hB00); expect_val(K_RDATA, "mcycle_wrap", 32'h0); settle(4);

        // drop to U, then reset asynchronously mid-cycle
        csrrw(12'h300, 32'h0); settle(4);
        drive(1'b1, 2'b00, 12'h0, 32'h0, 2'b01, 1'b0, 32'h0, 32'h0);
        expect_val(K_RPC, "pre_rst_rpc", 32'h508); settle(4);
        rd(12'h341); expect_val(K_PRIV, "pre_rst_priv", 32'd0); expect_val(K_RDATA, "pre_rst_mepc", 32'h508); settle(2);
        rstn = 1'b0;
        expect_val(K_PRIV, "arst_priv", 32'd3); expect_val(K_RDATA, "arst_mepc", 32'h0); settle(1);
        rd(12'h305); expect_val(K_RDATA, "arst_mtvec", 32'h1000); settle(4);
        @(negedge clk);
        rstn = 1'b1;
        csr_addr = 12'hB00;
        expect_val(K_RDATA, "arst_mcycle", 32'h0); settle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
